// File: rtl/axi_wr_burst_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wr_burst_if
//  Purpose  : Bundles the command, FIFO read-side, AXI4 AW/W/B and status
//             signals used by axi_wr_burst.
//  Ports    : master modport = burst engine side (drives AW/W, FIFO rden,
//             cmd_ready, status); slave modport = environment side (drives
//             command, FIFO data/empty, AXI ready/valid responses).
//  Revision : 1.0  initial release
// ============================================================================
interface axi_wr_burst_if #(
    parameter int AWID = 32,
    parameter int DWID = 32
);
    // Command
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AWID-1:0]   cmd_addr;
    logic [7:0]        cmd_len;
    // FIFO read side
    logic              fifo_rden;
    logic [DWID-1:0]   fifo_dout;
    logic              fifo_bare;
    // AXI write address
    logic              awvalid;
    logic              awready;
    logic [AWID-1:0]   awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    // AXI write data
    logic              wvalid;
    logic              wready;
    logic [DWID-1:0]   wdata;
    logic [DWID/8-1:0] wstrb;
    logic              wlast;
    // AXI write response
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    // Status
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        input  fifo_dout, fifo_bare,
        input  awready, wready, bvalid, bresp,
        output cmd_ready, fifo_rden,
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        output fifo_dout, fifo_bare,
        output awready, wready, bvalid, bresp,
        input  cmd_ready, fifo_rden,
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/axi_wr_burst.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wr_burst
//  Purpose  : AXI4 write-burst master. Accepts a (start address, awlen)
//             command, issues one INCR burst on AW, streams words read from
//             an upstream synchronous FIFO (one-cycle read latency) through a
//             two-entry holding buffer onto W, then waits for B.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-low reset
//             bus  - axi_wr_burst_if.master (command, FIFO, AW/W/B, status)
//  Revision : 1.0  initial release
// ============================================================================
module axi_wr_burst #(
    parameter int AWID = 32,
    parameter int DWID = 32
) (
    input  logic                clk,
    input  logic                rst,
    axi_wr_burst_if.master      bus
);

    localparam logic [2:0] C_AWSIZE = 3'($clog2(DWID / 8));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AWID-1:0]   addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [8:0]        fetch_left_q, fetch_left_d;
    logic [8:0]        send_left_q, send_left_d;
    logic              err_q, err_d;

    // Two-entry holding buffer (circular)
    logic [DWID-1:0]   buf_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              inflight_q;

    logic              w_wvalid;
    logic              w_pop;
    logic              w_rden;
    logic [2:0]        w_proj;

    // ------------------------------------------------------------------
    // Datapath / prefetch control
    // ------------------------------------------------------------------
    assign w_wvalid = (state_q == S_DATA) && (cnt_q != 2'd0);
    assign w_pop    = w_wvalid && bus.wready;
    // Occupancy the buffer will reach once the word in flight lands and
    // this cycle's pop retires; a new read is only safe if it stays < 2.
    assign w_proj   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_rden   = ((state_q == S_ADDR) || (state_q == S_DATA)) &&
                      !bus.fifo_bare && (fetch_left_q != 9'd0) &&
                      (w_proj < 3'd2);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        fetch_left_d = fetch_left_q;
        send_left_d  = send_left_q;
        err_d        = err_q;

        if (w_rden) fetch_left_d = fetch_left_q - 9'd1;
        if (w_pop)  send_left_d  = send_left_q - 9'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d       = bus.cmd_addr;
                    len_d        = bus.cmd_len;
                    fetch_left_d = {1'b0, bus.cmd_len} + 9'd1;
                    send_left_d  = {1'b0, bus.cmd_len} + 9'd1;
                    err_d        = 1'b0;
                    state_d      = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.awready) state_d = S_DATA;
            end
            S_DATA: begin
                if (w_pop && (send_left_q == 9'd1)) state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.bvalid) begin
                    err_d   = bus.bresp[1];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and buffer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            fetch_left_q <= '0;
            send_left_q  <= '0;
            err_q        <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            fetch_left_q <= fetch_left_d;
            send_left_q  <= send_left_d;
            err_q        <= err_d;
            inflight_q   <= w_rden;
            // FIFO data is valid the cycle after the read was issued
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= bus.fifo_dout;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, w_pop};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.fifo_rden = w_rden;
    assign bus.awvalid   = (state_q == S_ADDR);
    assign bus.awaddr    = addr_q;
    assign bus.awlen     = len_q;
    assign bus.awsize    = C_AWSIZE;
    assign bus.awburst   = 2'b01;
    assign bus.wvalid    = w_wvalid;
    assign bus.wdata     = buf_q[rd_ptr_q];
    assign bus.wstrb     = '1;
    assign bus.wlast     = w_wvalid && (send_left_q == 9'd1);
    assign bus.bready    = (state_q == S_RESP);
    assign bus.done      = (state_q == S_RESP) && bus.bvalid;
    assign bus.err       = err_q;

    // Only bresp[1] (SLVERR/DECERR) matters for the error flag
    logic w_unused_ok;
    assign w_unused_ok = bus.bresp[0];

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_wr_burst
//  Purpose  : Self-checking bench for axi_wr_burst with a FIFO model and
//             AW/W/B scoreboards.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_wr_burst;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_wr_burst_if #(.AWID(AW), .DWID(DW)) bif ();

    axi_wr_burst #(.AWID(AW), .DWID(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- FIFO model (one-cycle read latency) ----------------
    logic [DW-1:0] fmem [0:63];
    int fwr = 0;
    int frd = 0;
    assign bif.fifo_bare = (fwr == frd);
    always @(posedge clk) begin
        if (bif.fifo_rden && (frd != fwr)) begin
            bif.fifo_dout <= fmem[frd % 64];
            frd <= frd + 1;
        end
    end

    task automatic push_fifo(input logic [DW-1:0] base, input int n);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            fmem[fwr % 64] = base + DW'(i);
            fwr++;
        end
    endtask

    // ---------------- W ready driver ----------------
    int   wmode = 0;   // 0: always ready, 1: toggle
    logic tog   = 1'b0;
    always @(posedge clk) begin
        #1;
        tog = ~tog;
        bif.wready = (wmode == 1) ? tog : 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- Scoreboards ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } wexp_t;
    wexp_t         wq [$];
    logic [AW-1:0] aq_addr [$];
    logic [7:0]    aq_len [$];
    logic          bq [$];

    // ---------------- Monitor (samples mid-cycle) ----------------
    int            beats = 0, done_seen = 0, rden_cnt = 0;
    int            first_w = -1, acc_m = 0, wlast_cyc = 0;
    logic          stall_prev = 0, pl = 0, prev_done = 0;
    logic          err_chk_next = 0, err_exp = 0;
    logic [DW-1:0] pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            wexp_t e;
            if (err_chk_next) check_eq("err_capture", bif.err, err_exp);
            err_chk_next = 0;
            if (bif.cmd_valid && bif.cmd_ready) begin
                acc_m   = cyc + 1;
                first_w = -1;
            end
            if (bif.awvalid) check_eq("aw_no_w", bif.wvalid, 0);
            if (bif.awvalid && bif.awready) begin
                if (aq_addr.size() == 0) check_eq("aw_unexp", 1, 0);
                else begin
                    check_eq("awaddr", bif.awaddr, aq_addr.pop_front());
                    check_eq("awlen", bif.awlen, aq_len.pop_front());
                    check_eq("awsize", bif.awsize, 3'd2);
                    check_eq("awburst", bif.awburst, 2'b01);
                end
            end
            if (bif.fifo_rden) begin
                rden_cnt++;
                check_eq("rden_bare", bif.fifo_bare, 0);
            end
            if (bif.wlast) check_eq("wlast_wv", bif.wvalid, 1);
            if (stall_prev) begin
                check_eq("stall_wv", bif.wvalid, 1);
                check_eq("stall_data", bif.wdata, pd);
                check_eq("stall_last", bif.wlast, pl);
            end
            if (bif.wvalid && first_w < 0) first_w = cyc;
            if (bif.wvalid && bif.wready) begin
                beats++;
                if (wq.size() == 0) check_eq("w_unexp", 1, 0);
                else begin
                    e = wq.pop_front();
                    check_eq("wdata", bif.wdata, e.d);
                    check_eq("wlast", bif.wlast, e.last);
                    check_eq("wstrb", bif.wstrb, 4'hF);
                end
                if (bif.wlast) wlast_cyc = cyc;
            end
            stall_prev = bif.wvalid && !bif.wready;
            pd = bif.wdata;
            pl = bif.wlast;
            if (bif.done) begin
                done_seen++;
                check_eq("done_pulse", prev_done, 0);
                check_eq("done_bhs", bif.bvalid && bif.bready, 1);
                check_eq("b_lat", cyc - wlast_cyc, 1);
                if (bq.size() == 0) check_eq("b_unexp", 1, 0);
                else begin
                    err_exp      = bq.pop_front();
                    err_chk_next = 1;
                end
            end
            prev_done = bif.done;
        end else begin
            stall_prev   = 0;
            prev_done    = 0;
            err_chk_next = 0;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic issue(input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [DW-1:0] base, input logic exp_err);
        wexp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.d    = base + DW'(i);
            e.last = (i == int'(len));
            wq.push_back(e);
        end
        aq_addr.push_back(a);
        aq_len.push_back(len);
        bq.push_back(exp_err);
        @(posedge clk); #1;
        bif.cmd_addr  = a;
        bif.cmd_len   = len;
        bif.cmd_valid = 1'b1;
        @(negedge clk);
        check_eq("cmd_ready", bif.cmd_ready, 1);
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (k < 300 && done_seen < target) begin
            @(posedge clk);
            k++;
        end
        check_eq("done_seen", done_seen, target);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ctl"}, {bif.busy, bif.done, bif.err, bif.awvalid, bif.wvalid,
                                 bif.wlast, bif.bready, bif.fifo_rden}, 8'h00);
        check_eq({tag, "_rdy"}, bif.cmd_ready, 1);
        check_eq({tag, "_awaddr"}, bif.awaddr, 0);
        check_eq({tag, "_awlen"}, bif.awlen, 0);
        check_eq({tag, "_wdata"}, bif.wdata, 0);
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        int r0, b0, d0, k;
        bif.cmd_valid = 1'b0;
        bif.cmd_addr  = '0;
        bif.cmd_len   = '0;
        bif.awready   = 1'b1;
        bif.bvalid    = 1'b1;
        bif.bresp     = 2'b00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Single beat
        push_fifo(32'hA5A5A5A5, 1);
        r0 = rden_cnt;
        issue(32'h1000, 8'd0, 32'hA5A5A5A5, 1'b0);
        wait_done(1);
        check_eq("single_lat", first_w - acc_m, 2);
        check_eq("single_rden", rden_cnt - r0, 1);

        // Streaming
        push_fifo(32'd1, 8);
        r0 = rden_cnt;
        issue(32'h2000, 8'd7, 32'd1, 1'b0);
        wait_done(2);
        check_eq("stream_rden", rden_cnt - r0, 8);
        check_eq("stream_span", wlast_cyc - first_w, 7);

        // Backpressure on AW then toggling W ready
        push_fifo(32'd1, 4);
        r0 = rden_cnt;
        wmode = 1;
        bif.awready = 1'b0;
        issue(32'h3000, 8'd3, 32'd1, 1'b0);
        repeat (4) @(posedge clk);
        #1 bif.awready = 1'b1;
        wait_done(3);
        wmode = 0;
        check_eq("bp_rden", rden_cnt - r0, 4);

        // FIFO underflow mid-burst
        push_fifo(32'h200, 2);
        r0 = rden_cnt;
        issue(32'h4000, 8'd3, 32'h200, 1'b0);
        repeat (10) @(posedge clk);
        push_fifo(32'h202, 2);
        wait_done(4);
        check_eq("uf_rden", rden_cnt - r0, 4);
        check_eq("uf_gap", (wlast_cyc - first_w) > 3, 1);

        // Error response: sticky until next accept
        push_fifo(32'h300, 1);
        @(posedge clk); #1;
        bif.bresp = 2'b10;
        issue(32'h5000, 8'd0, 32'h300, 1'b1);
        wait_done(5);
        #1 bif.bresp = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check_eq("err_sticky", bif.err, 1);
        end
        check_eq("err_idle", bif.busy, 0);
        push_fifo(32'h400, 2);
        issue(32'h6000, 8'd1, 32'h400, 1'b0);
        @(negedge clk);
        check_eq("err_clr", bif.err, 0);
        wait_done(6);

        // Reset mid-burst after 2 of 4 beats
        push_fifo(32'h500, 4);
        b0 = beats;
        issue(32'h7000, 8'd3, 32'h500, 1'b0);
        k = 0;
        while (k < 100 && beats < b0 + 2) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_wait", beats >= b0 + 2, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        wq.delete();
        bq.delete();
        d0 = done_seen;
        b0 = beats;
        @(negedge clk);
        check_idle_outputs("midrst");
        repeat (10) @(posedge clk);
        check_eq("midrst_beats", beats, b0);
        check_eq("midrst_done", done_seen, d0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/axi_wr_burst.md
# axi_wr_burst

Single-clock AXI4 write-burst master that drains the read side of the team's synchronous FIFO (read-on-enable, one-cycle read latency, `bare` = empty flag) onto an AXI4 write address/data/response channel. A command (start address, beat count) launches one INCR burst; the block prefetches FIFO words into a two-entry holding buffer, streams them on W with `wlast` on the final beat, then waits for B. It sits directly downstream of the FIFO, between the datapath producer and the interconnect.

## Interface
- `AWID`, 32, address width.
- `DWID`, 32, data width; must match the FIFO; power of two, 8..1024.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets).
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake.
- `cmd_addr`  in  AWID  burst start byte address.
- `cmd_len`  in  8  beats minus one (AXI `awlen` encoding).
- `fifo_rden`  out  1  FIFO read enable.
- `fifo_dout`  in  DWID  FIFO read data, valid the cycle after `fifo_rden`.
- `fifo_bare`  in  1  FIFO empty.
- `awvalid` / `awready`  out / in  1; `awaddr` out AWID; `awlen` out 8; `awsize` out 3; `awburst` out 2.
- `wvalid` / `wready`  out / in  1; `wdata` out DWID; `wstrb` out DWID/8; `wlast` out 1.
- `bvalid` / `bready`  in / out  1; `bresp` in 2.
- `busy`  out  1  high whenever not IDLE.
- `done`  out  1  one-cycle pulse on B handshake.
- `err`  out  1  sticky; set when accepted `bresp[1]`=1, cleared on next command accept.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch addr/len, load `fetch_left` = `send_left` = `cmd_len`+1 (9-bit), clear `err`, go to ADDR.
- ADDR: `awvalid`=1 with latched values; on `awready` go to DATA.
- DATA: `wvalid` = holding buffer non-empty; `wdata` = buffer head; `wlast` = (`send_left`==1) and `wvalid`. Each W handshake pops one entry and decrements `send_left`; handshake with `wlast` goes to RESP.
- RESP: `bready`=1; on `bvalid` pulse `done`, capture `err` = `bresp[1]`, go to IDLE.
- Constants: `awsize` = log2(DWID/8), `awburst` = 2'b01 (INCR), `wstrb` all ones.
- Prefetch, in ADDR and DATA only: `fifo_rden` = !`fifo_bare` & `fetch_left`!=0 & (`cnt` + `inflight` − `pop`) < 2, where `cnt` = buffer entries (0..2), `inflight` = `fifo_rden` of previous cycle, `pop` = `wvalid`&`wready`. Each `fifo_rden` decrements `fetch_left`. When `inflight`=1, `fifo_dout` is written into the buffer that cycle.
- Buffer never overflows and never underflows; `fifo_rden` is never asserted while `fifo_bare`=1 or after `fetch_left` reaches 0.
- `cmd_addr` 4 KB-boundary legality and `cmd_len` ≤ 255 are the caller's responsibility; not checked.

## Timing
- Reset: state IDLE; `cmd_ready`=1; `busy`, `done`, `err`, `awvalid`, `wvalid`, `wlast`, `bready`, `fifo_rden`=0; `awaddr`, `awlen`, `wdata`=0; buffer, `cnt`, `inflight`, counters cleared. Applies mid-burst: the burst is abandoned, already-fetched FIFO words are dropped, and no `wlast`/`done` is issued.
- Command accepted at edge T: `awvalid`=1 and `busy`=1 from T+1; `fifo_rden` earliest T+1; data in buffer from T+2 edge; `wvalid` earliest cycle T+3, provided AW completed by then.
- AW and W never overlap: `wvalid`=0 in ADDR even if buffer full.
- Sustained throughput: 1 beat/cycle while `fifo_bare`=0 and `wready`=1.
- `fifo_bare` mid-burst: `wvalid` drops after buffer drains; `wlast` never asserted early.
- `wready`=0: `wdata`/`wlast` held stable while `wvalid`=1 (AXI rule); prefetch stops at 2 entries.
- `done` is high exactly one cycle, coincident with the B handshake; `cmd_ready` returns to 1 the next cycle, so back-to-back commands have a 1-cycle gap.
- `cmd_valid` outside IDLE is ignored.

## Test plan
- Single beat: FIFO holds 0xA5A5A5A5, cmd_len=0, addr=0x1000, AW/W/B ready=1 -> awlen=0, one W beat 0xA5A5A5A5 with `wlast`=1 at T+3, `done` one cycle later, `err`=0.
- Streaming: FIFO holds 1..8, cmd_len=7, all ready=1 -> wdata 1..8 on 8 consecutive cycles, `wlast` only on 8, exactly 8 `fifo_rden` pulses.
- Backpressure: cmd_len=3, `wready` toggles 1,0,1,0… -> data 1..4 in order, stable while stalled, `cnt` ≤ 2, no extra `fifo_rden`.
- Underflow: FIFO holds 2 words, cmd_len=3; push 2 more 10 cycles later -> `wvalid` gaps while `fifo_bare`=1, no `fifo_rden` while bare, `wlast` on 4th beat only.
- Error response: bresp=2'b10 -> `done` pulse, `err`=1 held through IDLE, cleared on next command accept.
- Reset mid-burst: `rst`=0 for one cycle after 2 of 4 beats -> all outputs at reset values next cycle, `cmd_ready`=1, no `wlast`/`done`.
